// File: rtl/memory_system.sv
// memory_system: memory-side responder for the CPU bus.
// Serves program ROM, data RAM, output ports and synchronised input ports
// at the byte address held in MAR. A stream loader fills ROM while the CPU is held.
module memory_system #(
  parameter int         ROM_DEPTH   = 128,
  parameter logic [7:0] RAM_BASE    = 8'h80,
  parameter int         RAM_DEPTH   = 96,
  parameter logic [7:0] OUT_BASE    = 8'hE0,
  parameter logic [7:0] IN_BASE     = 8'hF0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [7:0]   address,
  input  logic [7:0]   data_in,
  input  logic         write,
  output logic [7:0]   from_memory,
  input  logic [127:0] port_in,
  output logic [127:0] port_out,
  input  logic         ld_start,
  input  logic         ld_valid,
  input  logic [7:0]   ld_data,
  input  logic         ld_last,
  output logic         ld_ready,
  output logic         ld_done,
  output logic         cpu_hold
);

  localparam int PTR_W  = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } ld_state_t;

  ld_state_t          ld_state, ld_state_next;
  logic [PTR_W-1:0]   ld_ptr;
  logic               rom_wr;

  logic [7:0]         rom [ROM_DEPTH];
  logic [7:0]         ram [RAM_DEPTH];
  logic [127:0]       port_out_q;
  logic [127:0]       sync_q [SYNC_STAGES];

  logic [8:0]         addr_ext;
  logic               is_rom, is_ram, is_out, is_in;
  logic [PTR_W-1:0]   rom_idx;
  logic [RAM_AW-1:0]  ram_idx;
  logic [3:0]         out_idx, in_idx;
  logic [7:0]         rd_data;

  assign port_out = port_out_q;

  // Address decode; comparisons are done 9 bits wide so range ends never wrap
  always_comb begin
    addr_ext = {1'b0, address};
    is_rom   = addr_ext < 9'(ROM_DEPTH);
    is_ram   = (addr_ext >= {1'b0, RAM_BASE}) &&
               (addr_ext < ({1'b0, RAM_BASE} + 9'(RAM_DEPTH)));
    is_out   = (addr_ext >= {1'b0, OUT_BASE}) &&
               (addr_ext < ({1'b0, OUT_BASE} + 9'd16));
    is_in    = (addr_ext >= {1'b0, IN_BASE}) &&
               (addr_ext < ({1'b0, IN_BASE} + 9'd16));
    rom_idx  = PTR_W'(address);
    ram_idx  = RAM_AW'(address - RAM_BASE);
    out_idx  = 4'(address - OUT_BASE);
    in_idx   = 4'(address - IN_BASE);
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_data = 8'h00;
    if (is_rom) begin
      rd_data = rom[rom_idx];
    end else if (is_ram) begin
      rd_data = ram[ram_idx];
    end else if (is_out) begin
      rd_data = port_out_q[{out_idx, 3'b000} +: 8];
    end else if (is_in) begin
      rd_data = sync_q[SYNC_STAGES-1][{in_idx, 3'b000} +: 8];
    end
  end

  // Registered read data, output-port writes and input synchroniser chain
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      from_memory <= 8'h00;
      port_out_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      from_memory <= rd_data;
      if (write && is_out) begin
        port_out_q[{out_idx, 3'b000} +: 8] <= data_in;
      end
      sync_q[0] <= port_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Memory arrays keep their contents across reset; nonblocking writes give read-first
  always_ff @(posedge Clk) begin
    if (rom_wr) begin
      rom[ld_ptr] <= ld_data;
    end
    if (write && is_ram) begin
      ram[ram_idx] <= data_in;
    end
  end

  // Loader state and fill pointer
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ld_state <= LD_IDLE;
      ld_ptr   <= '0;
    end else begin
      ld_state <= ld_state_next;
      if (ld_state == LD_IDLE && ld_start) begin
        ld_ptr <= '0;
      end else if (rom_wr) begin
        ld_ptr <= ld_ptr + 1'b1;
      end
    end
  end

  // Loader next state and handshake outputs; the last ROM slot ends a load even without ld_last
  always_comb begin
    ld_state_next = ld_state;
    ld_ready      = 1'b0;
    ld_done       = 1'b0;
    cpu_hold      = 1'b0;
    rom_wr        = 1'b0;
    case (ld_state)
      LD_IDLE: begin
        if (ld_start) begin
          ld_state_next = LD_LOAD;
        end
      end
      LD_LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (ld_valid) begin
          rom_wr = 1'b1;
          if (ld_last || ld_ptr == PTR_W'(ROM_DEPTH - 1)) begin
            ld_state_next = LD_DONE;
          end
        end
      end
      LD_DONE: begin
        ld_done       = 1'b1;
        cpu_hold      = 1'b1;
        ld_state_next = LD_IDLE;
      end
      default: begin
        ld_state_next = LD_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_system.sv
// tb_memory_system: randomized self-checking bench for memory_system.
// A behavioural model (arrays, a delay-line queue and a load flag) predicts every output.
module tb_memory_system;

  localparam int ROM_DEPTH   = 128;
  localparam int RAM_BASE    = 128;
  localparam int RAM_DEPTH   = 96;
  localparam int OUT_BASE    = 224;
  localparam int IN_BASE     = 240;
  localparam int SYNC_STAGES = 2;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [7:0]   address;
  logic [7:0]   data_in;
  logic         write;
  logic [7:0]   from_memory;
  logic [127:0] port_in;
  logic [127:0] port_out;
  logic         ld_start;
  logic         ld_valid;
  logic [7:0]   ld_data;
  logic         ld_last;
  logic         ld_ready;
  logic         ld_done;
  logic         cpu_hold;

  memory_system dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .address     (address),
    .data_in     (data_in),
    .write       (write),
    .from_memory (from_memory),
    .port_in     (port_in),
    .port_out    (port_out),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .cpu_hold    (cpu_hold)
  );

  always #5 Clk = ~Clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state
  logic [7:0]   rom_m [ROM_DEPTH];
  bit           rom_k [ROM_DEPTH];
  logic [7:0]   ram_m [RAM_DEPTH];
  bit           ram_k [RAM_DEPTH];
  logic [127:0] pout_m;
  logic [127:0] inq [$];
  bit           m_loading;
  bit           m_done;
  int           m_ptr;

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_known(input logic [7:0] a);
    int ai = int'(a);
    if (ai < ROM_DEPTH) return rom_k[ai];
    if (ai >= RAM_BASE && ai < RAM_BASE + RAM_DEPTH) return ram_k[ai - RAM_BASE];
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int ai = int'(a);
    if (ai < ROM_DEPTH) return rom_m[ai];
    if (ai >= RAM_BASE && ai < RAM_BASE + RAM_DEPTH) return ram_m[ai - RAM_BASE];
    if (ai >= OUT_BASE && ai < OUT_BASE + 16) return pout_m[(ai - OUT_BASE) * 8 +: 8];
    if (ai >= IN_BASE && ai < IN_BASE + 16) return inq[0][(ai - IN_BASE) * 8 +: 8];
    return 8'h00;
  endfunction

  // One clock cycle: predict, advance the model, clock the DUT, compare
  task automatic apply_stimulus();
    logic [7:0] exp_rd;
    bit         known;
    int         ai;
    exp_rd = model_read(address);
    known  = model_known(address);
    ai     = int'(address);
    if (write) begin
      if (ai >= RAM_BASE && ai < RAM_BASE + RAM_DEPTH) begin
        ram_m[ai - RAM_BASE] = data_in;
        ram_k[ai - RAM_BASE] = 1'b1;
      end else if (ai >= OUT_BASE && ai < OUT_BASE + 16) begin
        pout_m[(ai - OUT_BASE) * 8 +: 8] = data_in;
      end
    end
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_loading) begin
      if (ld_valid) begin
        rom_m[m_ptr] = ld_data;
        rom_k[m_ptr] = 1'b1;
        if (ld_last || m_ptr == ROM_DEPTH - 1) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
        m_ptr++;
      end
    end else if (ld_start) begin
      m_loading = 1'b1;
      m_ptr     = 0;
    end
    inq.push_back(port_in);
    void'(inq.pop_front());
    @(posedge Clk);
    @(negedge Clk);
    if (known) check_output("from_memory", from_memory, exp_rd);
    check_output("port_out", port_out, pout_m);
    check_output("ready/done/hold", {ld_ready, ld_done, cpu_hold},
                 {m_loading, m_done, m_loading | m_done});
  endtask

  task automatic do_reset();
    write    = 1'b0;
    ld_valid = 1'b0;
    ld_start = 1'b0;
    ld_last  = 1'b0;
    Reset    = 1'b0;
    #2;
    pout_m    = '0;
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_ptr     = 0;
    inq       = {};
    repeat (SYNC_STAGES) inq.push_back('0);
    check_output("reset from_memory", from_memory, 8'h00);
    check_output("reset port_out", port_out, '0);
    check_output("reset ready/done/hold", {ld_ready, ld_done, cpu_hold}, 3'b000);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      write    = 1'b0;
      ld_valid = 1'b0;
      ld_start = 1'b0;
      apply_stimulus();
    end
  endtask

  task automatic read_addr(input logic [7:0] a);
    address = a;
    write   = 1'b0;
    apply_stimulus();
  endtask

  task automatic write_addr(input logic [7:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    write   = 1'b1;
    apply_stimulus();
    write   = 1'b0;
  endtask

  // Start a load and stream n_send bytes with random stalls; noisy adds stray starts and CPU reads
  task automatic load_bytes(input logic [7:0] vals[$], input bit mark_last,
                            input int n_send, input bit noisy);
    write    = 1'b0;
    ld_start = 1'b1;
    apply_stimulus();
    ld_start = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      int stalls;
      stalls = $urandom_range(0, 2);
      repeat (stalls) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        ld_last  = 1'($urandom_range(0, 1));
        ld_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) address = 8'($urandom);
        apply_stimulus();
      end
      ld_valid = 1'b1;
      ld_data  = vals[i];
      ld_last  = mark_last && (i == vals.size() - 1);
      ld_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) address = 8'($urandom);
      apply_stimulus();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_start = 1'b0;
  endtask

  initial begin
    logic [7:0] vals[$];
    Reset    = 1'b0;
    address  = 8'h00;
    data_in  = 8'h00;
    write    = 1'b0;
    port_in  = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    ld_last  = 1'b0;
    pout_m   = '0;
    for (int i = 0; i < ROM_DEPTH; i++) rom_k[i] = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) ram_k[i] = 1'b0;
    @(negedge Clk);
    do_reset();

    $display("[TB] three-byte load ending on ld_last");
    vals = '{8'hA1, 8'hB2, 8'hC3};
    load_bytes(vals, 1'b1, 3, 1'b0);
    idle(1);
    read_addr(8'h00);
    read_addr(8'h01);
    read_addr(8'h02);
    check_output("rom[2] after load", from_memory, 8'hC3);

    $display("[TB] reset in the middle of a load");
    vals = '{8'h11, 8'h22, 8'h33};
    load_bytes(vals, 1'b0, 2, 1'b0);
    do_reset();
    idle(2);
    read_addr(8'h00);
    check_output("rom[0] kept", from_memory, 8'h11);
    read_addr(8'h01);
    read_addr(8'h02);
    check_output("rom[2] untouched", from_memory, 8'hC3);

    $display("[TB] full-depth load without ld_last");
    vals = {};
    for (int i = 0; i < ROM_DEPTH; i++) vals.push_back(8'($urandom));
    load_bytes(vals, 1'b0, ROM_DEPTH, 1'b1);
    idle(2);

    $display("[TB] RAM fill and read-first write");
    for (int a = RAM_BASE; a < RAM_BASE + RAM_DEPTH; a++) write_addr(8'(a), 8'($urandom));
    write_addr(8'h80, 8'h5A);
    read_addr(8'h80);
    check_output("ram[80] new value", from_memory, 8'h5A);

    $display("[TB] output port and ROM write protection");
    write_addr(8'hE3, 8'h3C);
    check_output("port_out[31:24]", port_out[31:24], 8'h3C);
    read_addr(8'hE3);
    write_addr(8'h10, 8'h77);
    read_addr(8'h10);

    $display("[TB] input port synchroniser latency");
    port_in = '0;
    port_in[15:8] = 8'h99;
    read_addr(8'hF1);
    read_addr(8'hF1);
    read_addr(8'hF1);
    check_output("in port after sync", from_memory, 8'h99);
    read_addr(8'hF1);

    $display("[TB] random CPU traffic");
    for (int n = 0; n < 500; n++) begin
      address = 8'($urandom);
      data_in = 8'($urandom);
      write   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) port_in = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus();
    end
    write = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
